vdp_sprite_meta_dma: RTL and testbench
======================================

# vdp_sprite_meta_dma

Bulk uploader for the sprite metadata blocks (x, y, g). On a start pulse it fetches a packed sprite table from a 16-bit source RAM through a single-outstanding read handshake, then drives the sprite core's metadata write port (`meta_address` / `meta_write_data` / `meta_block_select` / `meta_we`). Writes are gated by `write_allowed`, so the CPU can queue an upload that only commits during blanking. It sits between the CPU-facing register file and `vdp_sprite_core`, and replaces per-word CPU metadata writes.

## Interface
- Parameters: none; sprite index is 8 bits, source address is 16 bits.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; ignored while `busy`.
- `abort` in 1: cancel the transfer in progress.
- `source_base_address` in 16: word address of the table entry for sprite `sprite_first`.
- `sprite_first` in 8: first metadata index written.
- `sprite_count` in 9: number of sprites, 0..256.
- `block_mask` in 3: bit0 = x, bit1 = y, bit2 = g; selects the blocks written.
- `write_allowed` in 1: metadata writes may commit this cycle.
- `busy` out 1: transfer active, including abort drain.
- `done` out 1: one-cycle pulse on normal completion.
- `src_read_address` out 16: source read address.
- `src_read_request` out 1: read request.
- `src_read_ready` in 1: request accepted at this edge.
- `src_read_data` in 16: returned word.
- `src_read_data_valid` in 1: `src_read_data` is valid.
- `meta_address` out 8: metadata index.
- `meta_write_data` out 16: word written.
- `meta_block_select` out 3: one-hot block select.
- `meta_we` out 1: write strobe.

## Operation
- **Table layout**
  - 3 words per sprite, in the order x, y, g.
  - Word k of sprite offset i is at `source_base_address + 3*i + k`, with 16-bit wrap.
  - Only masked words are fetched; unmasked words are skipped with no read.
- **Latched at accepted start:** base, first, count and mask. Inputs may change afterwards without effect.
- **States**
  - IDLE: accepts `start`.
  - REQ: `src_read_request`=1 with address stable until `src_read_ready`=1 at a rising edge, then go to WAIT.
  - WAIT: on `src_read_data_valid`, capture data into a hold register and go to WRITE.
  - WRITE:
    - `meta_we` = `write_allowed` (combinational).
    - Address, data and select come from registers.
    - Stay in WRITE while `write_allowed`=0.
    - On commit, advance to the next masked word (REQ), or to the next sprite (REQ), or finish (DONE).
  - DONE: pulse `done`, then return to IDLE.
  - DRAIN: abort issued while a read is outstanding; wait for `src_read_data_valid`, discard the data, then go to IDLE.
- **Start with count=0 or mask=0:** no reads, no writes; REQ is bypassed and DONE follows directly.
- **`meta_address` wrap:** `sprite_first + i` mod 256. A count of 256 starting at a nonzero first wraps past 255 to 0.
- **`meta_block_select`:** exactly one bit set while `meta_we`=1. When mask has more than one bit set, the order within a sprite is x, y, g.
- **`abort`**
  - In REQ or WRITE: go to IDLE next cycle; no write that cycle; no `done`.
  - In WAIT: go to DRAIN.
  - In IDLE: no effect.
  - `abort` and `start` in the same cycle while IDLE: `start` is ignored.
- **Arithmetic:** the sprite counter is 9 bits and terminates after `sprite_count` sprites. The address counter is 16-bit with an increment of 1 per word slot, including skipped slots (i.e. +3 per sprite).

## Timing
- **Reset values:** all outputs 0; state IDLE; hold register 0.
- **Start to first request:** `start` sampled at edge 0 gives `busy`=1 and `src_read_request`=1 from cycle 1.
- **Request:** may be accepted in the cycle it is raised. It deasserts the cycle after acceptance.
- **Data path:** valid at edge N gives WRITE in cycle N+1, so `meta_we` can be high in cycle N+1.
- **Next request:** raised the cycle after the committing write.
- **Peak rate:** with zero-wait source and `write_allowed`=1, one word per 3 cycles (REQ, WAIT, WRITE).
- **Completion:** `done`=1 for one cycle after the last commit, and `busy` falls in the same cycle. For count=0, `done` is in cycle 1.
- **`src_read_data_valid` outside WAIT/DRAIN:** ignored.
- **Reset mid-transfer:** immediate return to IDLE with outputs 0. A late valid after reset is ignored.

## Test plan
- **Basic upload.** base=0x1000, first=4, count=2, mask=111, zero-latency source, `write_allowed`=1.
  - Reads: 0x1000..0x1005.
  - Writes: (4,x), (4,y), (4,g), (5,x), (5,y), (5,g) with the source data.
  - `done` 1 cycle after the 6th write.
- **Partial mask and wrap.** mask=100, first=255, count=2, base=0xFFFE.
  - Reads: 0x0000, 0x0003 (16-bit wrap).
  - Writes: g block at indices 255 then 0.
- **Write gating.** `write_allowed` held low for 10 cycles.
  - `meta_we` stays 0 and no further `src_read_request` is issued.
  - When `write_allowed` rises, the write commits that cycle.
- **Empty transfer.** count=0.
  - `busy` high for cycle 1 only; `done` in cycle 1; no requests; no writes.
- **Abort while waiting.** Abort in WAIT with valid arriving 4 cycles later.
  - `busy` stays 1 until the valid, then 0.
  - No write and no `done`; the next `start` works normally.
- **Back-pressure.** `src_read_ready` low for 5 cycles.
  - Address held constant and request held high.
  - A `start` pulse while busy is ignored; the transfer result is unchanged.

Source files
------------

// File: rtl/vdp_sprite_meta_dma.sv
// Sprite metadata uploader: fetches packed (x, y, g) words from source RAM
// and replays them into the sprite core's metadata write port.
module vdp_sprite_meta_dma (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] source_base_address,
    input  logic [7:0]  sprite_first,
    input  logic [8:0]  sprite_count,
    input  logic [2:0]  block_mask,
    input  logic        write_allowed,
    output logic        busy,
    output logic        done,
    output logic [15:0] src_read_address,
    output logic        src_read_request,
    input  logic        src_read_ready,
    input  logic [15:0] src_read_data,
    input  logic        src_read_data_valid,
    output logic [7:0]  meta_address,
    output logic [15:0] meta_write_data,
    output logic [2:0]  meta_block_select,
    output logic        meta_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sprite_addr_q, sprite_addr_d;
    logic [1:0]  slot_q, slot_d;
    logic [8:0]  idx_q, idx_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  first_q, first_d;
    logic [2:0]  mask_q, mask_d;
    logic [15:0] hold_q, hold_d;
    logic [2:0]  start_slot, restart_slot, next_slot_in_sprite;
    logic        in_write;

    // {found, slot}: lowest set mask bit, optionally only above 'after'
    function automatic logic [2:0] pick_slot(input logic [2:0] mask,
                                             input logic [1:0] after,
                                             input logic       any);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            if (mask[k] && (any || k[1:0] > after)) r = {1'b1, k[1:0]};
        end
        return r;
    endfunction

    assign start_slot          = pick_slot(block_mask, 2'd0, 1'b1);
    assign restart_slot        = pick_slot(mask_q, 2'd0, 1'b1);
    assign next_slot_in_sprite = pick_slot(mask_q, slot_q, 1'b0);

    always_comb begin
        state_d       = state_q;
        sprite_addr_d = sprite_addr_q;
        slot_d        = slot_q;
        idx_d         = idx_q;
        count_d       = count_q;
        first_d       = first_q;
        mask_d        = mask_q;
        hold_d        = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sprite_addr_d = source_base_address;
                    first_d       = sprite_first;
                    count_d       = sprite_count;
                    mask_d        = block_mask;
                    idx_d         = 9'd0;
                    slot_d        = start_slot[1:0];
                    if (sprite_count == 9'd0 || !start_slot[2]) state_d = S_DONE;
                    else state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) state_d = S_IDLE;
                else if (src_read_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (src_read_data_valid) hold_d = src_read_data;
                // A word landing with the abort has nothing left to drain
                if (abort) state_d = src_read_data_valid ? S_IDLE : S_DRAIN;
                else if (src_read_data_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (write_allowed) begin
                    if (next_slot_in_sprite[2]) begin
                        slot_d  = next_slot_in_sprite[1:0];
                        state_d = S_REQ;
                    end else if (idx_q + 9'd1 == count_q || !restart_slot[2]) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d         = idx_q + 9'd1;
                        sprite_addr_d = sprite_addr_q + 16'd3;
                        slot_d        = restart_slot[1:0];
                        state_d       = S_REQ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            S_DRAIN: begin
                if (src_read_data_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sprite_addr_q <= 16'd0;
            slot_q        <= 2'd0;
            idx_q         <= 9'd0;
            count_q       <= 9'd0;
            first_q       <= 8'd0;
            mask_q        <= 3'd0;
            hold_q        <= 16'd0;
        end else begin
            state_q       <= state_d;
            sprite_addr_q <= sprite_addr_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            first_q       <= first_d;
            mask_q        <= mask_d;
            hold_q        <= hold_d;
        end
    end

    assign in_write          = (state_q == S_WRITE);
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign src_read_request  = (state_q == S_REQ);
    assign src_read_address  = sprite_addr_q + {14'd0, slot_q};
    assign meta_address      = first_q + idx_q[7:0];
    assign meta_write_data   = hold_q;
    assign meta_block_select = in_write ? (3'b001 << slot_q) : 3'b000;
    assign meta_we           = in_write && write_allowed && !abort;

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Self-checking bench for vdp_sprite_meta_dma against a table-walk model
// with a randomized single-outstanding source and write gating.
module tb_vdp_sprite_meta_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] source_base_address = 16'd0;
    logic [7:0]  sprite_first = 8'd0;
    logic [8:0]  sprite_count = 9'd0;
    logic [2:0]  block_mask = 3'd0;
    logic        write_allowed = 1'b0;
    logic        src_read_ready = 1'b0;
    logic [15:0] src_read_data = 16'd0;
    logic        src_read_data_valid = 1'b0;
    logic        busy, done, src_read_request, meta_we;
    logic [15:0] src_read_address, meta_write_data;
    logic [7:0]  meta_address;
    logic [2:0]  meta_block_select;

    vdp_sprite_meta_dma dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .source_base_address(source_base_address),
        .sprite_first(sprite_first), .sprite_count(sprite_count),
        .block_mask(block_mask), .write_allowed(write_allowed),
        .busy(busy), .done(done),
        .src_read_address(src_read_address),
        .src_read_request(src_read_request),
        .src_read_ready(src_read_ready), .src_read_data(src_read_data),
        .src_read_data_valid(src_read_data_valid),
        .meta_address(meta_address), .meta_write_data(meta_write_data),
        .meta_block_select(meta_block_select), .meta_we(meta_we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [15:0] seed16 = 16'h1234;

    int lat = 0;
    int ready_hold = 0;
    bit rnd_bus = 0;
    int wa_lo = 0, wa_hi = 0;
    int abort_rel = -1;
    bit abort_force = 0;

    bit pend = 0;
    int dly = 0;
    logic [15:0] pend_addr = 16'd0;

    logic [15:0] rd_q[$];
    logic [26:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [15:0] exp_rd[$];
    logic [26:0] exp_wr[$];
    int first_req_cyc, done_cnt, done_cyc, busy_cnt, last_busy_cyc;
    int valid_cyc, hold_err, start_cyc, req_in_win;
    logic [15:0] prev_req_addr;
    bit prev_req_wait = 0;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return (a * 16'h9E37) ^ seed16;
    endfunction

    function automatic bit in_win(input int c);
        return start_cyc >= 0 && (c - start_cyc) >= wa_lo && (c - start_cyc) < wa_hi;
    endfunction

    // Source RAM responder and bus monitor, one pass per cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            src_read_data_valid = 1'b0;
            src_read_data = 16'($urandom);
            if (pend) begin
                if (dly == 0) begin
                    src_read_data_valid = 1'b1;
                    src_read_data = word_at(pend_addr);
                    pend = 0;
                    valid_cyc = cyc;
                end else dly--;
            end else if (rnd_bus && $urandom_range(4) == 0) begin
                src_read_data_valid = 1'b1;
            end
            abort = abort_force ||
                    (abort_rel >= 0 && start_cyc >= 0 && cyc - start_cyc == abort_rel);
            if (start && !busy && !abort) start_cyc = cyc;
            if (rnd_bus) begin
                src_read_ready = ($urandom_range(3) != 0);
                write_allowed = ($urandom_range(2) != 0);
            end else begin
                src_read_ready = (ready_hold == 0);
                write_allowed = !in_win(cyc);
            end
            if (src_read_request) begin
                if (prev_req_wait && src_read_address !== prev_req_addr) hold_err++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (in_win(cyc)) req_in_win++;
                if (src_read_ready) begin
                    rd_q.push_back(src_read_address);
                    pend = 1;
                    dly = lat;
                    pend_addr = src_read_address;
                    prev_req_wait = 0;
                end else begin
                    prev_req_wait = 1;
                    prev_req_addr = src_read_address;
                    if (ready_hold > 0) ready_hold--;
                end
            end else prev_req_wait = 0;
            #1;
            if (meta_we) begin
                wr_q.push_back({meta_address, meta_block_select, meta_write_data});
                wr_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                busy_cnt++;
                last_busy_cyc = cyc;
            end
        end
    end

    task automatic clear_obs();
        rd_q.delete();
        wr_q.delete();
        wr_cyc_q.delete();
        first_req_cyc = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        last_busy_cyc = -1; valid_cyc = -1; hold_err = 0; start_cyc = -1;
        req_in_win = 0;
    endtask

    task automatic build_exp(input logic [15:0] b, input logic [7:0] f,
                             input logic [8:0] c, input logic [2:0] m);
        logic [15:0] a;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < int'(c); i++) begin
            for (int k = 0; k < 3; k++) begin
                if (m[k]) begin
                    a = b + 16'(3 * i + k);
                    exp_rd.push_back(a);
                    exp_wr.push_back({8'(f + i), 3'(1 << k), word_at(a)});
                end
            end
        end
    endtask

    task automatic launch(input logic [15:0] b, input logic [7:0] f,
                          input logic [8:0] c, input logic [2:0] m);
        @(negedge clk);
        source_base_address = b;
        sprite_first = f;
        sprite_count = c;
        block_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        source_base_address = 16'($urandom);
        sprite_first = 8'($urandom);
        sprite_count = 9'($urandom);
        block_mask = 3'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        n_checks++;
        if ({busy, done, src_read_request, src_read_address, meta_address,
             meta_write_data, meta_block_select, meta_we} !== 62'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b req=%b we=%b addr=%h", busy,
                     src_read_request, meta_we, src_read_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        clear_obs();
        build_exp(16'h1000, 8'd4, 9'd2, 3'b111);
        launch(16'h1000, 8'd4, 9'd2, 3'b111);
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy stuck"); end
        n_checks++;
        if (rd_q.size() != 6 || wr_q.size() != 6) begin
            n_fail++;
            $display("FAIL basic_counts: reads=%0d writes=%0d want 6/6", rd_q.size(), wr_q.size());
        end
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (j >= rd_q.size() || j >= wr_q.size() || rd_q[j] !== exp_rd[j] ||
                wr_q[j] !== exp_wr[j] || wr_cyc_q[j] != start_cyc + 3 * (j + 1)) begin
                n_fail++;
                $display("FAIL basic_word%0d: want rd=%h wr=%h at cycle %0d", j,
                         exp_rd[j], exp_wr[j], start_cyc + 3 * (j + 1));
            end
        end
        n_checks++;
        if (first_req_cyc != start_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_first_req: got %0d want %0d", first_req_cyc, start_cyc + 1);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != start_cyc + 19 || last_busy_cyc != done_cyc) begin
            n_fail++;
            $display("FAIL basic_done: got cnt=%0d cyc=%0d lastbusy=%0d want 1/%0d", done_cnt,
                     done_cyc, last_busy_cyc, start_cyc + 19);
        end
    endtask

    task automatic test_mask_wrap();
        bit ok;
        clear_obs();
        build_exp(16'hFFFE, 8'd255, 9'd2, 3'b100);
        launch(16'hFFFE, 8'd255, 9'd2, 3'b100);
        wait_idle(200, ok);
        n_checks++;
        if (!ok || rd_q.size() != 2 || wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_counts: reads=%0d writes=%0d want 2/2", rd_q.size(), wr_q.size());
        end
        n_checks++;
        if (rd_q.size() == 2 && (rd_q[0] !== 16'h0000 || rd_q[1] !== 16'h0003)) begin
            n_fail++;
            $display("FAIL wrap_reads: got %h %h want 0000 0003", rd_q[0], rd_q[1]);
        end
        n_checks++;
        if (wr_q.size() == 2 && (wr_q[0] !== exp_wr[0] || wr_q[1] !== exp_wr[1])) begin
            n_fail++;
            $display("FAIL wrap_writes: got %h %h want %h %h", wr_q[0], wr_q[1],
                     exp_wr[0], exp_wr[1]);
        end
    endtask

    task automatic test_write_gating();
        bit ok;
        logic [15:0] b;
        b = 16'($urandom);
        clear_obs();
        build_exp(b, 8'd17, 9'd1, 3'b011);
        wa_lo = 3;
        wa_hi = 13;
        launch(b, 8'd17, 9'd1, 3'b011);
        wait_idle(200, ok);
        wa_lo = 0;
        wa_hi = 0;
        n_checks++;
        if (!ok || wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL gate_counts: writes=%0d want 2", wr_q.size());
        end
        n_checks++;
        if (wr_cyc_q.size() == 2 && (wr_cyc_q[0] != start_cyc + 13 ||
                                     wr_cyc_q[1] != start_cyc + 16)) begin
            n_fail++;
            $display("FAIL gate_commit_cycle: got +%0d +%0d want +13 +16",
                     wr_cyc_q[0] - start_cyc, wr_cyc_q[1] - start_cyc);
        end
        n_checks++;
        if (req_in_win != 0) begin
            n_fail++;
            $display("FAIL gate_no_request: got %0d requests want 0", req_in_win);
        end
        n_checks++;
        if (wr_q.size() == 2 && (wr_q[0] !== exp_wr[0] || wr_q[1] !== exp_wr[1])) begin
            n_fail++;
            $display("FAIL gate_data: got %h %h want %h %h", wr_q[0], wr_q[1],
                     exp_wr[0], exp_wr[1]);
        end
    endtask

    task automatic test_empty();
        bit ok;
        for (int t = 0; t < 2; t++) begin
            clear_obs();
            if (t == 0) launch(16'($urandom), 8'($urandom), 9'd0, 3'b111);
            else launch(16'($urandom), 8'($urandom), 9'd5, 3'b000);
            wait_idle(20, ok);
            repeat (2) @(negedge clk);
            n_checks++;
            if (!ok || done_cnt != 1 || done_cyc != start_cyc + 1 || busy_cnt != 1) begin
                n_fail++;
                $display("FAIL empty%0d_done: got done=%0d at +%0d busy=%0d want 1 at +1 busy=1",
                         t, done_cnt, done_cyc - start_cyc, busy_cnt);
            end
            n_checks++;
            if (rd_q.size() != 0 || wr_q.size() != 0 || first_req_cyc != -1) begin
                n_fail++;
                $display("FAIL empty%0d_traffic: got reads=%0d writes=%0d want 0/0", t,
                         rd_q.size(), wr_q.size());
            end
        end
    endtask

    task automatic test_abort_wait();
        bit ok;
        clear_obs();
        lat = 4;
        abort_rel = 2;
        launch(16'h0200, 8'd9, 9'd3, 3'b111);
        wait_idle(50, ok);
        abort_rel = -1;
        lat = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || valid_cyc != start_cyc + 6 || last_busy_cyc != valid_cyc) begin
            n_fail++;
            $display("FAIL abort_drain: got valid +%0d lastbusy +%0d want +6 +6",
                     valid_cyc - start_cyc, last_busy_cyc - start_cyc);
        end
        n_checks++;
        if (wr_q.size() != 0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_silent: got writes=%0d done=%0d want 0/0", wr_q.size(), done_cnt);
        end
        clear_obs();
        build_exp(16'h0300, 8'd40, 9'd2, 3'b011);
        launch(16'h0300, 8'd40, 9'd2, 3'b011);
        wait_idle(200, ok);
        n_checks++;
        if (!ok || wr_q != exp_wr || rd_q != exp_rd || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_restart: got writes=%0d reads=%0d done=%0d want %0d/%0d/1",
                     wr_q.size(), rd_q.size(), done_cnt, exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic test_abort_idle();
        clear_obs();
        @(negedge clk);
        sprite_count = 9'd3;
        block_mask = 3'b111;
        start = 1'b1;
        abort_force = 1;
        @(negedge clk);
        start = 1'b0;
        abort_force = 0;
        repeat (4) @(negedge clk);
        #3;
        n_checks++;
        if (busy_cnt != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_start_same_cycle: got busy cycles=%0d want 0", busy_cnt);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        clear_obs();
        build_exp(16'h4440, 8'd100, 9'd2, 3'b101);
        ready_hold = 5;
        launch(16'h4440, 8'd100, 9'd2, 3'b101);
        repeat (2) @(negedge clk);
        source_base_address = 16'h7000;
        sprite_first = 8'd1;
        sprite_count = 9'd7;
        block_mask = 3'b111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (first_req_cyc != start_cyc + 1 || hold_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got first req +%0d addr changes=%0d want +1/0",
                     first_req_cyc - start_cyc, hold_err);
        end
        n_checks++;
        if (wr_cyc_q.size() == 0 || wr_cyc_q[0] != start_cyc + 8) begin
            n_fail++;
            $display("FAIL bp_first_write: got %0d writes want first at +8", wr_cyc_q.size());
        end
        n_checks++;
        if (!ok || wr_q != exp_wr || rd_q != exp_rd || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_result: got writes=%0d reads=%0d done=%0d want %0d/%0d/1",
                     wr_q.size(), rd_q.size(), done_cnt, exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        lat = 3;
        launch(16'h0100, 8'd0, 9'd3, 3'b111);
        @(negedge clk);
        reset_n = 1'b0;
        #3;
        n_checks++;
        if ({busy, done, src_read_request, src_read_address, meta_address,
             meta_write_data, meta_block_select, meta_we} !== 62'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b req=%b addr=%h", busy,
                     src_read_request, src_read_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_obs();
        repeat (8) @(negedge clk);
        #3;
        lat = 0;
        n_checks++;
        if (busy !== 1'b0 || wr_q.size() != 0 || rd_q.size() != 0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_late_valid: got busy=%b writes=%0d want 0/0", busy, wr_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [15:0] b;
        logic [7:0] f;
        logic [8:0] c;
        logic [2:0] m;
        rnd_bus = 1;
        for (int t = 0; t < 8; t++) begin
            b = 16'($urandom);
            f = (t == 0) ? 8'($urandom_range(255, 1)) : 8'($urandom);
            c = (t == 0) ? 9'd256 : 9'($urandom_range(6));
            m = (t == 0) ? 3'b001 : 3'($urandom_range(7));
            lat = $urandom_range(3);
            clear_obs();
            build_exp(b, f, c, m);
            launch(b, f, c, m);
            wait_idle(20000, ok);
            n_checks++;
            if (!ok || done_cnt != 1 || hold_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_done: got done=%0d holderr=%0d want 1/0", t,
                         done_cnt, hold_err);
            end
            n_checks++;
            if (rd_q != exp_rd || wr_q != exp_wr) begin
                n_fail++;
                $display("FAIL rand%0d_traffic: got reads=%0d writes=%0d want %0d/%0d", t,
                         rd_q.size(), wr_q.size(), exp_rd.size(), exp_wr.size());
            end
        end
        rnd_bus = 0;
        lat = 0;
    endtask

    initial begin
        seed16 = 16'($urandom);
        test_reset();
        test_basic();
        test_mask_wrap();
        test_write_gating();
        test_empty();
        test_abort_wait();
        test_abort_idle();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
